// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int          INST_BYTES       = 4;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, one-entry buffer to decode; REQ/WAIT/HOLD gives 3 cycles/inst.
// Backpressure: decode holds the buffer (and stops new requests) via inst_ready; redirects squash wrong-path words.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [PC_W-1:0]  inst_pc,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic             r_sq;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_inst_pc;
    logic [31:0]      r_inst;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    logic [PC_W-1:0]  w_redir_pc;
    logic             w_accept;
    logic             w_rsp;
    logic             w_capture;
    logic             w_deliver;
    logic             w_squash;
    logic             w_unused;

    assign w_redir_pc = {redirect_pc[PC_W-1:2], 2'b00};
    assign w_unused   = ^redirect_pc[1:0];

    assign w_accept  = (r_state == REQ) && imem_req_ready;
    assign w_rsp     = (r_state == WAIT) && imem_rsp_valid;
    // A response is kept only if no redirect has touched it, either earlier (sq) or now.
    assign w_capture = w_rsp && !r_sq && !redirect_valid;
    assign w_deliver = (r_state == HOLD) && inst_ready && !redirect_valid;
    assign w_squash  = (w_rsp && (r_sq || redirect_valid)) ||
                       ((r_state == HOLD) && redirect_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            REQ:     if (imem_req_ready) w_state_nxt = WAIT;
            WAIT:    if (imem_rsp_valid) w_state_nxt = w_capture ? HOLD : REQ;
            HOLD:    if (redirect_valid || inst_ready) w_state_nxt = REQ;
            default: w_state_nxt = REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (r_state == REQ);
        inst_valid     = (r_state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq      <= 1'b0;
            r_pc      <= RESET_PC;
            r_inst    <= NOP_INST;
            r_inst_pc <= '0;
        end else begin
            if (w_accept) begin
                r_sq <= redirect_valid;
            end else if (w_rsp) begin
                r_sq <= 1'b0;
            end else if ((r_state == WAIT) && redirect_valid) begin
                r_sq <= 1'b1;
            end

            if (redirect_valid) begin
                r_pc <= w_redir_pc;
            end else if (w_deliver) begin
                r_pc <= r_pc + PC_W'(INST_BYTES);
            end

            if (w_capture) begin
                r_inst    <= imem_rsp_data;
                r_inst_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_deliver) r_fetch_cnt  <= r_fetch_cnt + CNT_W'(1);
            if (w_squash)  r_squash_cnt <= r_squash_cnt + CNT_W'(1);
        end
    end

    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign fetch_cnt  = r_fetch_cnt;
    assign squash_cnt = r_squash_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against an address-stream reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;

    fetch_ctrl #(.PC_W(64), .RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_cnt      (fetch_cnt),
        .squash_cnt     (squash_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus knobs
    logic        drv_inst_ready;
    logic        drv_redirect;
    logic [63:0] drv_redirect_pc;
    int          cfg_ready_pct;
    int          cfg_lat_min;
    int          cfg_lat_span;

    // memory and reference model: expected fetch address plus delivered/issued counts
    bit          mem_pending;
    logic [63:0] mem_addr;
    int          mem_delay;
    logic [63:0] m_exp_pc;
    int          m_deliv;
    int          m_acc;

    // pre-edge observations from the last step
    logic        o_req_valid, o_inst_valid, o_accept, o_rsp, o_deliver;
    logic [63:0] o_addr, o_inst_pc, o_exp_pc;
    logic [31:0] o_inst, o_fcnt, o_scnt;
    int          o_deliv, o_acc;

    function automatic logic [31:0] memf(input logic [63:0] a);
        if (a == 64'h0) return 32'h00A0_0093;
        return a[31:0] ^ {a[63:34], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    task automatic model_reset();
        m_exp_pc    = 64'h0;
        m_deliv     = 0;
        m_acc       = 0;
        mem_pending = 1'b0;
        mem_delay   = 0;
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        drv_inst_ready = 1'b0;
        drv_redirect   = 1'b0;
        drv_redirect_pc = 64'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: drive at negedge, observe, let the edge happen, advance models.
    task automatic step();
        @(negedge clk);
        imem_rsp_valid = mem_pending && (mem_delay == 0);
        imem_rsp_data  = imem_rsp_valid ? memf(mem_addr) : $urandom;
        imem_req_ready = ($urandom_range(0, 99) < cfg_ready_pct);
        inst_ready     = drv_inst_ready;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        #1;
        o_req_valid  = imem_req_valid;
        o_addr       = imem_addr;
        o_inst_valid = inst_valid;
        o_inst       = inst;
        o_inst_pc    = inst_pc;
        o_fcnt       = fetch_cnt;
        o_scnt       = squash_cnt;
        o_exp_pc     = m_exp_pc;
        o_deliv      = m_deliv;
        o_acc        = m_acc;
        o_accept     = imem_req_valid && imem_req_ready;
        o_rsp        = imem_rsp_valid;
        o_deliver    = inst_valid && inst_ready && !redirect_valid;
        @(posedge clk);
        if (redirect_valid)  m_exp_pc = {redirect_pc[63:2], 2'b00};
        else if (o_deliver)  m_exp_pc = m_exp_pc + 64'd4;
        if (o_deliver) m_deliv++;
        if (o_accept)  m_acc++;
        if (o_rsp)     mem_pending = 1'b0;
        if (o_accept) begin
            mem_pending = 1'b1;
            mem_addr    = o_addr;
            mem_delay   = cfg_lat_min - 1 + int'($urandom_range(0, cfg_lat_span));
        end else if (mem_pending && mem_delay > 0) begin
            mem_delay--;
        end
        #1;
        drv_redirect = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_req_valid got %b want 1", imem_req_valid); end
        n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
        n_checks++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst got %h want 00000013", inst); end
        n_checks++; if (inst_pc !== 64'h0) begin n_fail++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
        n_checks++; if (fetch_cnt !== 32'h0 || squash_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", fetch_cnt, squash_cnt); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_stream();
        int first;
        logic [63:0] pcs[$];
        do_reset();
        cfg_ready_pct = 100; cfg_lat_min = 1; cfg_lat_span = 0;
        drv_inst_ready = 1'b1;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (o_inst_valid && first == 0) first = k;
            if (o_deliver) pcs.push_back(o_inst_pc);
        end
        n_checks++; if (first != 3) begin n_fail++; $display("FAIL stream_first_valid got cycle %0d want 3", first); end
        n_checks++; if (pcs.size() != 4) begin n_fail++; $display("FAIL stream_count got %0d want 4", pcs.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < pcs.size()) begin
                n_checks++; if (pcs[i] !== 64'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h want %h", i, pcs[i], 64'(4 * i)); end
            end
        end
        n_checks++; if (fetch_cnt !== 32'd4) begin n_fail++; $display("FAIL stream_fetch_cnt got %0d want 4", fetch_cnt); end
    endtask

    task automatic test_stall();
        bit found;
        do_reset();
        cfg_ready_pct = 100; cfg_lat_min = 1; cfg_lat_span = 0;
        drv_inst_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            found = o_inst_valid;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL stall_reach_hold got no inst_valid want one within 10 cycles"); end
        for (int s = 0; s < 5; s++) begin
            if (s > 0) step();
            n_checks++; if (o_inst !== 32'h00A0_0093 || o_inst_pc !== 64'h0) begin n_fail++; $display("FAIL stall_buffer[%0d] got %h@%h want 00a00093@0", s, o_inst, o_inst_pc); end
            n_checks++; if (o_req_valid !== 1'b0 || o_addr !== 64'h0) begin n_fail++; $display("FAIL stall_no_req[%0d] got vld=%b addr=%h want 0/0", s, o_req_valid, o_addr); end
        end
        drv_inst_ready = 1'b1;
        step();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h4) begin n_fail++; $display("FAIL stall_release got vld=%b addr=%h want 1/4", imem_req_valid, imem_addr); end
        n_checks++; if (fetch_cnt !== 32'd1 || m_acc != 1) begin n_fail++; $display("FAIL stall_counts got fetch=%0d reqs=%0d want 1/1", fetch_cnt, m_acc); end
    endtask

    task automatic test_redirect_wait();
        bit found;
        do_reset();
        cfg_ready_pct = 100; cfg_lat_min = 4; cfg_lat_span = 0;
        drv_inst_ready = 1'b1;
        step();
        drv_redirect = 1'b1; drv_redirect_pc = 64'h100;
        step();
        step();
        step();
        n_checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rwait_waiting got req=%b inst=%b want 0/0", imem_req_valid, inst_valid); end
        step();
        n_checks++; if (squash_cnt !== 32'd1) begin n_fail++; $display("FAIL rwait_squash got %0d want 1", squash_cnt); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h100) begin n_fail++; $display("FAIL rwait_next_req got vld=%b addr=%h want 1/100", imem_req_valid, imem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rwait_dropped got inst_valid=%b want 0", inst_valid); end
        cfg_lat_min = 1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            found = o_deliver;
        end
        n_checks++; if (!found || o_inst_pc !== 64'h100 || o_inst !== memf(64'h100)) begin n_fail++; $display("FAIL rwait_deliver got found=%b %h@%h want %h@100", found, o_inst, o_inst_pc, memf(64'h100)); end
    endtask

    task automatic test_redirect_hold();
        bit found;
        do_reset();
        cfg_ready_pct = 100; cfg_lat_min = 1; cfg_lat_span = 0;
        drv_inst_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            found = o_inst_valid;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rhold_reach_hold got no inst_valid want one within 10 cycles"); end
        drv_redirect = 1'b1; drv_redirect_pc = 64'h203; drv_inst_ready = 1'b1;
        step();
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rhold_discard got inst_valid=%b want 0", inst_valid); end
        n_checks++; if (fetch_cnt !== 32'd0 || squash_cnt !== 32'd1) begin n_fail++; $display("FAIL rhold_counts got fetch=%0d squash=%0d want 0/1", fetch_cnt, squash_cnt); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h200) begin n_fail++; $display("FAIL rhold_addr got vld=%b addr=%h want 1/200", imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_handshake();
        bit found;
        do_reset();
        cfg_ready_pct = 100; cfg_lat_min = 2; cfg_lat_span = 0;
        drv_inst_ready = 1'b1;
        drv_redirect = 1'b1; drv_redirect_pc = 64'h300;
        step();
        n_checks++; if (o_accept !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rhs_issued got acc=%b req_now=%b want 1/0", o_accept, imem_req_valid); end
        step();
        step();
        n_checks++; if (squash_cnt !== 32'd1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rhs_dropped got squash=%0d inst_valid=%b want 1/0", squash_cnt, inst_valid); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h300) begin n_fail++; $display("FAIL rhs_next_req got vld=%b addr=%h want 1/300", imem_req_valid, imem_addr); end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            found = o_deliver;
        end
        n_checks++; if (!found || o_inst_pc !== 64'h300) begin n_fail++; $display("FAIL rhs_deliver got found=%b pc=%h want 300", found, o_inst_pc); end
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        cfg_ready_pct = 100; cfg_lat_min = 1; cfg_lat_span = 0;
        drv_inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        cfg_lat_min = 3;
        step();
        n_checks++; if (imem_req_valid !== 1'b0 || fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL arst_pre got req=%b fetch=%0d want 0/2", imem_req_valid, fetch_cnt); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL arst_outputs got req=%b addr=%h iv=%b want 1/0/0", imem_req_valid, imem_addr, inst_valid); end
        n_checks++; if (fetch_cnt !== 32'd0 || inst !== 32'h0000_0013 || inst_pc !== 64'h0) begin n_fail++; $display("FAIL arst_regs got fetch=%0d inst=%h pc=%h want 0/00000013/0", fetch_cnt, inst, inst_pc); end
        clear_inputs();
        model_reset();
        drv_inst_ready = 1'b1;
        cfg_lat_min = 1;
        @(posedge clk);
        #1 rst = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            found = o_deliver;
        end
        n_checks++; if (!found || o_inst_pc !== 64'h0 || fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL arst_restart got found=%b pc=%h fetch=%0d want 0/1", found, o_inst_pc, fetch_cnt); end
    endtask

    task automatic test_random();
        logic [63:0] t;
        do_reset();
        cfg_ready_pct = 60; cfg_lat_min = 1; cfg_lat_span = 3;
        for (int k = 0; k < 3000; k++) begin
            drv_inst_ready = ($urandom_range(0, 99) < 70);
            drv_redirect   = ($urandom_range(0, 99) < 8);
            t = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) t = {32'hFFFF_FFFF, 32'hFFFF_FFF0 | ($urandom & 32'hF)};
            drv_redirect_pc = t;
            step();
            n_checks++; if (o_req_valid && o_inst_valid) begin n_fail++; $display("FAIL rnd_both_valid[%0d] got req=1 inst=1 want exclusive", k); end
            if (o_req_valid) begin
                n_checks++; if (o_addr !== o_exp_pc) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", k, o_addr, o_exp_pc); end
                n_checks++; if (o_fcnt !== 32'(o_deliv) || o_scnt !== 32'(o_acc - o_deliv)) begin n_fail++; $display("FAIL rnd_counts[%0d] got %0d/%0d want %0d/%0d", k, o_fcnt, o_scnt, o_deliv, o_acc - o_deliv); end
            end
            if (o_inst_valid) begin
                n_checks++; if (o_inst_pc !== o_exp_pc || o_inst !== memf(o_exp_pc)) begin n_fail++; $display("FAIL rnd_inst[%0d] got %h@%h want %h@%h", k, o_inst, o_inst_pc, memf(o_exp_pc), o_exp_pc); end
            end
        end
        n_checks++; if (m_deliv < 100) begin n_fail++; $display("FAIL rnd_progress got %0d deliveries want >=100", m_deliv); end
        n_checks++; if (fetch_cnt !== 32'(m_deliv)) begin n_fail++; $display("FAIL rnd_final_fetch got %0d want %0d", fetch_cnt, m_deliv); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        cfg_ready_pct = 100; cfg_lat_min = 1; cfg_lat_span = 0;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_handshake();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch sequencer for the RISC-V core. It owns the program counter, issues one outstanding request at a time to instruction memory, and buffers the returned word in a single-entry output register. It presents the word to the decode stage (control decode plus immediate generation) over a valid/ready handshake. Taken branches and jumps redirect it, and any in-flight or buffered wrong-path instruction is squashed.

## Interface
- PC_W, 64: program counter width.
- RESET_PC, 64'h0: PC loaded on reset.
- CNT_W, 32: width of performance counters.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  PC_W  fetch address, stable while imem_req_valid.
- imem_rsp_valid  in  1  one-cycle pulse with read data; at most one per accepted request, never before the cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  buffered instruction valid to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  PC_W  address of inst.
- redirect_valid  in  1  taken branch/jump/jalr, one-cycle pulse.
- redirect_pc  in  PC_W  target; bits [1:0] forced to 0.
- fetch_cnt  out  CNT_W  instructions delivered to decode.
- squash_cnt  out  CNT_W  instructions or responses discarded.

## Operation
- State register with states REQ, WAIT, HOLD; squash flag `sq`; registers `pc`, `inst`, `inst_pc`.
- REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready, go to WAIT with sq=0.
- WAIT: imem_req_valid=0. On imem_rsp_valid:
  - sq=0: capture inst=imem_rsp_data, inst_pc=pc, go to HOLD.
  - sq=1: drop the response, increment squash_cnt, clear sq, go to REQ.
- HOLD: inst_valid=1. On inst_ready: pc=pc+4 (wraps modulo 2^PC_W), increment fetch_cnt, go to REQ.
- Redirect has priority over everything else in the same cycle. pc is loaded with {redirect_pc[PC_W-1:2],2'b00}.
  - REQ, no handshake: stay in REQ; the new address appears next cycle.
  - REQ with imem_req_ready in the same cycle: the request counts as issued. Go to WAIT with sq=1.
  - WAIT, no response: set sq=1 and stay in WAIT.
  - WAIT with imem_rsp_valid in the same cycle: drop the response, increment squash_cnt, go to REQ.
  - HOLD: discard the buffer (inst_valid=0 next cycle) and increment squash_cnt. A same-cycle inst_ready is ignored: no pc+4 and no fetch_cnt increment. Go to REQ.
- imem_rsp_valid in REQ or HOLD is a protocol error and is ignored.
- inst and inst_pc hold their value while inst_valid=1 and inst_ready=0.

## Timing
- Reset values: state=REQ, pc=RESET_PC, sq=0, imem_req_valid=1, imem_addr=RESET_PC, inst_valid=0, inst=32'h00000013, inst_pc=0, fetch_cnt=0, squash_cnt=0.
- Reset is asynchronous, so assertion mid-transaction aborts it immediately. A response arriving after rst deasserts while in REQ is ignored under the rule above.
- All outputs are registered except imem_req_valid, imem_addr and inst_valid, which decode directly from the state register and pc with no input-to-output path.
- With zero-wait memory (ready=1, response the cycle after acceptance) and decode always ready, throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect-to-request latency is 1 cycle from REQ or HOLD. From WAIT it is response arrival plus 1 cycle.
- Counters wrap at 2^CNT_W.

## Structure
- Shared package fetch_pkg: state enum (REQ, WAIT, HOLD), INST_BYTES=4, NOP_INST=32'h00000013 (addi x0,x0,0), and the default RESET_PC.
- No sub-module is needed. The single-entry buffer and the counters stay inline.

## Test plan
- Reset, zero-wait memory, decode always ready: inst_pc sequence 0, 4, 8, 12; first inst_valid in cycle 3 after reset release; fetch_cnt=4 after 12 cycles.
- Decode stalls for 5 cycles in HOLD with inst=32'h00A00093: inst and inst_pc stay stable, no new imem request is issued, pc increments only on the ready cycle.
- Redirect to 64'h100 while in WAIT, response 3 cycles later: response dropped, squash_cnt=1, next imem_addr=64'h100, next delivered inst_pc=64'h100.
- Redirect to 64'h203 in HOLD with inst_ready=1 in the same cycle: buffer discarded, fetch_cnt unchanged, squash_cnt increments, imem_addr=64'h200.
- Redirect coincident with the imem_req_ready handshake: the following response is dropped and the next request goes to the redirect target.
- rst asserted while in WAIT: outputs return to reset values asynchronously, and fetch restarts at RESET_PC after deassertion.
